// File: rtl/led_sweep_decoder.sv
// led_sweep_decoder: locks onto an 8-LED ping-pong sweep and recovers its index and direction.
// Define LED_SWEEP_DECODER_ERRCNT_EN to add the saturating o_err_count output.
module led_sweep_decoder #(
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_led,
  output logic       o_locked,
  output logic [3:0] o_index,
  output logic       o_dir,
`ifdef LED_SWEEP_DECODER_ERRCNT_EN
  output logic [7:0] o_err_count,
`endif
  output logic       o_err
);

  localparam int unsigned LED_W    = 8;
  localparam int unsigned POS_W    = 3;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned STREAK_W = 3;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(14);
  localparam logic [IDX_W-1:0] IDX_TURN = IDX_W'(8);

  typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic [POS_W-1:0]    p_prev;
  logic                prev_valid;

  logic                is_blank_c;
  logic                is_valid_c;
  logic [POS_W-1:0]    pos_c;
  logic                adjacent_c;
  logic [STREAK_W-1:0] streak_inc_c;
  logic                lock_hit_c;
  logic                lock_dir_c;
  logic [IDX_W-1:0]    lock_index_c;
  logic [IDX_W-1:0]    next_idx_c;
  logic [LED_W-1:0]    exp_pattern_c;
  logic                match_c;
  logic                err_event_c;

  // Classify the sample and locate the lit bit.
  always_comb begin
    is_blank_c = (i_led == '0);
    is_valid_c = !is_blank_c && ((i_led & (i_led - LED_W'(1))) == '0);
    pos_c      = '0;
    for (int i = 0; i < int'(LED_W); i++) begin
      if (i_led[i]) pos_c = POS_W'(i);
    end
  end

  // Streak bookkeeping while searching; compare in 4 bits so 7/0 never look adjacent.
  always_comb begin
    adjacent_c   = prev_valid &&
                   ((IDX_W'(pos_c) == IDX_W'(p_prev) + IDX_W'(1)) ||
                    (IDX_W'(p_prev) == IDX_W'(pos_c) + IDX_W'(1)));
    streak_inc_c = streak + STREAK_W'(1);
    lock_hit_c   = adjacent_c && (streak_inc_c == STREAK_W'(LOCK_COUNT));
    lock_dir_c   = (pos_c > p_prev);
    if (pos_c == POS_W'(0))
      lock_index_c = IDX_W'(1);
    else if (pos_c == POS_W'(7))
      lock_index_c = IDX_W'(8);
    else if (lock_dir_c)
      lock_index_c = IDX_W'(pos_c) + IDX_W'(1);
    else
      lock_index_c = IDX_W'(15) - IDX_W'(pos_c);
  end

  // Pattern expected for the next sweep index while locked.
  always_comb begin
    next_idx_c = (o_index == IDX_LAST) ? IDX_W'(1) : o_index + IDX_W'(1);
    if (next_idx_c <= IDX_TURN)
      exp_pattern_c = LED_W'(1) << POS_W'(next_idx_c - IDX_W'(1));
    else
      exp_pattern_c = LED_W'(1) << POS_W'(IDX_W'(15) - next_idx_c);
    match_c     = (i_led == exp_pattern_c);
    err_event_c = (state == ST_LOCKED) && !is_blank_c && !match_c;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_SEARCH;
      streak     <= '0;
      p_prev     <= '0;
      prev_valid <= 1'b0;
      o_locked   <= 1'b0;
      o_index    <= '0;
      o_dir      <= 1'b1;
      o_err      <= 1'b0;
    end else begin
      o_err <= 1'b0;
      if (!is_blank_c) begin
        unique case (state)
          ST_SEARCH: begin
            if (is_valid_c) begin
              p_prev     <= pos_c;
              prev_valid <= 1'b1;
              if (lock_hit_c) begin
                state    <= ST_LOCKED;
                o_locked <= 1'b1;
                o_index  <= lock_index_c;
                o_dir    <= lock_dir_c;
                streak   <= '0;
              end else if (adjacent_c) begin
                streak <= streak_inc_c;
              end else begin
                streak <= '0;
              end
            end else begin
              streak     <= '0;
              prev_valid <= 1'b0;
            end
          end
          ST_LOCKED: begin
            if (err_event_c) begin
              state      <= ST_SEARCH;
              o_locked   <= 1'b0;
              o_index    <= '0;
              o_err      <= 1'b1;
              streak     <= '0;
              prev_valid <= is_valid_c;
              if (is_valid_c) p_prev <= pos_c;
            end else begin
              o_index <= next_idx_c;
              o_dir   <= (next_idx_c <= IDX_TURN);
            end
          end
        endcase
      end
    end
  end

`ifdef LED_SWEEP_DECODER_ERRCNT_EN
  // Counts alongside the o_err pulse and sticks at all-ones.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      o_err_count <= '0;
    else if (err_event_c && (o_err_count != 8'hFF))
      o_err_count <= o_err_count + 8'd1;
  end
`endif

endmodule

// File: doc/led_sweep_decoder.md
LED_SWEEP_DECODER -- requirements
Module: led_sweep_decoder

Interface
REQ-001 Parameter LOCK_COUNT, default 2, is the number of consecutive adjacent one-hot steps required to acquire lock; legal range 1..7.
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_reset  input  1  asynchronous, active-high reset.
REQ-004 i_led  input  8  observed LED bus driven by the sweep generator; sampled every i_clk rising edge.
REQ-005 o_locked  output  1  high while the decoder is tracking a valid sweep.
REQ-006 o_index  output  4  recovered sweep index 1..14 while locked; 0 while unlocked.
REQ-007 o_dir  output  1  recovered direction of the last step: 1 = toward bit7, 0 = toward bit0.
REQ-008 o_err  output  1  one-cycle pulse on loss of lock.
REQ-009 o_err_count  output  8  saturating error count; present only under the macro in REQ-025.

Function
REQ-010 Sample classes: blank (i_led == 0), valid (exactly one bit set, at position p = 0..7), or invalid (two or more bits set).
REQ-011 Sweep sequence: index k = 1..8 lights bit k-1; index k = 9..14 lights bit 15-k; index 14 is followed by index 1.
REQ-012 FSM has two states, SEARCH and LOCKED; all outputs are registered and reflect the sample taken at the same edge (1-cycle latency).
REQ-013 Blank samples in either state hold all state and outputs unchanged, except o_err, which is 0; blank samples never advance, count, or flag.
REQ-014 SEARCH: a valid sample with |p - p_prev| == 1 against the last valid sample increments the streak; any other valid sample sets the streak to 0 and records p as p_prev.
REQ-015 SEARCH: an invalid sample clears the streak and the p_prev-valid flag, and does not assert o_err.
REQ-016 SEARCH -> LOCKED when the streak reaches LOCK_COUNT; on that edge o_dir = (p > p_prev), and o_index = p+1 if o_dir = 1, 15-p if o_dir = 0, forced to 1 at p = 0 and to 8 at p = 7.
REQ-017 LOCKED: a non-blank sample is compared with the expected pattern of index (o_index mod 14)+1; on a match, o_index advances with wrap 14 -> 1 and o_dir is updated (1 for next indices 2..8, 0 for 9..14 and 1... wrap keeps o_dir = 1 after 14 -> 1).
REQ-018 LOCKED: a mismatch (a wrong valid bit, an invalid sample, or a repeat of the current pattern) pulses o_err for 1 cycle, clears o_locked and o_index to 0, clears the streak, records the sample as p_prev if valid, and returns to SEARCH.
REQ-019 A re-lock after an error requires a full LOCK_COUNT streak again; there is no fast re-acquire.
REQ-020 o_locked is 1 exactly when the state is LOCKED.

Reset
REQ-021 Asserting i_reset immediately forces SEARCH, a streak of 0, p_prev invalid, o_locked=0, o_index=0, o_dir=1, o_err=0, and o_err_count=0.
REQ-022 A reset asserted while LOCKED aborts tracking without an o_err pulse.
REQ-023 The first edge after reset deassertion processes i_led normally under SEARCH rules.

Configuration
REQ-024 Without the macro, o_err_count is absent from the port list and no counter logic is instantiated.
REQ-025 With LED_SWEEP_DECODER_ERRCNT_EN defined, o_err_count increments on each o_err pulse and saturates at 8'hFF.

Verification
REQ-026 Reset, then drive 01,02,04,08 -> o_locked rises on the 04 sample edge with o_index=3, o_dir=1; the 08 edge gives o_index=4.
REQ-027 When locked, drive the full sweep through 80,40,...,02,01 -> o_index reads 8,9..14,1, o_dir falls at index 9 and returns to 1 after the wrap, and o_err stays 0.
REQ-028 When locked at index 5 (10), drive 40 -> o_err is high for exactly 1 cycle, o_locked=0, and o_index=0.
REQ-029 When locked, insert 3 blank cycles between 08 and 10 -> o_index holds at 4 through the blanks, then reads 5, and there is no error.
REQ-030 In SEARCH, drive 01,03,02,04 -> no lock and no o_err, since the invalid sample clears the streak; lock occurs only at the 04 edge when LOCK_COUNT=1.
REQ-031 With the macro defined, force 300 errors -> o_err_count reads 8'hFF; assert i_reset mid-LOCKED -> all outputs are 0 except o_dir=1, with no o_err pulse.
